irq_trap_ctrl: RTL and testbench

Parametrised machine-mode trap controller, successor to the single-external-line controller. Sits beside the pipeline's CSR unit; it arbitrates exceptions, NUM_IRQ external interrupt lines and the system timer interrupt, and drives trap/nextPC to the fetch stage. It adds the following over the previous generation:
- asynchronous-input synchronisers
- per-source level/edge trigger mode with pending latches
- MPIE save/restore across trap and iret
- mtval capture
- optional vectored dispatch

---
 rtl/irq_trap_ctrl.sv | 168 ++++++++++++++++
 tb/tb_irq_trap_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_trap_ctrl.sv
// Machine-mode trap controller: exceptions, NUM_IRQ synchronised external lines and the timer.
// Optional vectored dispatch enabled by defining IRQ_TRAP_VECTORED_EN.
module irq_trap_ctrl #(
  parameter int unsigned NUM_IRQ = 4
) (
  input  logic               CLK,
  input  logic               reset,
  output logic               trap,
  input  logic [31:0]        savePC,
  output logic [31:0]        nextPC,
  input  logic               iret,
  input  logic [NUM_IRQ-1:0] externalIRQ,
  input  logic               systemTimerIRQ,
  input  logic               exception,
  input  logic [7:0]         exceptionCode,
  input  logic [31:0]        exceptionValue,
  input  logic [4:0]         A,
  input  logic               WE,
  input  logic [31:0]        WD,
  output logic [31:0]        RD
);

  logic [NUM_IRQ-1:0] sync_meta, sync_s, sync_d, edge_pend;
  logic [NUM_IRQ-1:0] mtrig, mie_ext;
  logic               mtie, st_mie, st_mpie;
  logic [31:0]        mepc, mcause, mtval, mscratch;
  logic [29:0]        mtvec_base;
  logic [1:0]         mtvec_mode;

  logic [NUM_IRQ-1:0] pending, irq_masked, take_vec, edge_set, edge_clr;
  logic               timer_term, found, int_take, trap_entry, do_iret, wr_mip;
  logic [3:0]         sel;
  logic [4:0]         cause;
  logic [31:0]        base, int_target;

  assign pending    = (mtrig & edge_pend) | (~mtrig & sync_s);
  assign irq_masked = pending & mie_ext;
  assign timer_term = mtie & systemTimerIRQ;

  always_comb begin
    found    = 1'b0;
    sel      = '0;
    take_vec = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (irq_masked[i] && !found) begin
        found       = 1'b1;
        sel         = i[3:0];
        take_vec[i] = 1'b1;
      end
    end
  end

  assign int_take   = st_mie & (found | timer_term) & ~exception;
  assign trap_entry = exception | int_take;
  assign do_iret    = iret & ~trap_entry;
  assign cause      = found ? (5'd16 + {1'b0, sel}) : 5'd7;
  assign base       = {mtvec_base, 2'b00};

`ifdef IRQ_TRAP_VECTORED_EN
  assign int_target = (mtvec_mode == 2'd1) ? (base + {25'b0, cause, 2'b00}) : base;
`else
  assign int_target = base;
  assign mtvec_mode = 2'b00;
`endif

  always_comb begin
    trap   = 1'b0;
    nextPC = mepc;
    if (exception) begin
      trap   = 1'b1;
      nextPC = base;
    end else if (int_take) begin
      trap   = 1'b1;
      nextPC = int_target;
    end else if (iret) begin
      trap   = 1'b1;
    end
  end

  // Set beats a same-cycle clear (W1C or auto-clear on the taking trap)
  assign wr_mip   = WE && (A == 5'd2);
  assign edge_set = sync_s & ~sync_d & mtrig;
  assign edge_clr = (wr_mip ? WD[NUM_IRQ-1:0] : '0) | ((int_take && found) ? take_vec : '0);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      sync_meta <= '0;
      sync_s    <= '0;
      sync_d    <= '0;
      edge_pend <= '0;
    end else begin
      sync_meta <= externalIRQ;
      sync_s    <= sync_meta;
      sync_d    <= sync_s;
      edge_pend <= (edge_pend & ~edge_clr) | edge_set;
    end
  end

  // CSR writes first; trap/iret updates later in the block override them
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mie_ext    <= '0;
      mtie       <= 1'b0;
      mepc       <= '0;
      mtvec_base <= '0;
      mcause     <= '0;
      mtval      <= '0;
      mscratch   <= '0;
      mtrig      <= '0;
`ifdef IRQ_TRAP_VECTORED_EN
      mtvec_mode <= '0;
`endif
    end else begin
      if (WE) begin
        case (A)
          5'd0: begin st_mie <= WD[0]; st_mpie <= WD[1]; end
          5'd1: begin mie_ext <= WD[NUM_IRQ-1:0]; mtie <= WD[16]; end
          5'd3: mepc <= WD;
          5'd4: begin
            mtvec_base <= WD[31:2];
`ifdef IRQ_TRAP_VECTORED_EN
            mtvec_mode <= WD[1:0];
`endif
          end
          5'd5: mcause   <= WD;
          5'd6: mtval    <= WD;
          5'd7: mscratch <= WD;
          5'd8: mtrig    <= WD[NUM_IRQ-1:0];
          default: ;
        endcase
      end
      if (trap_entry) begin
        st_mpie <= st_mie;
        st_mie  <= 1'b0;
        mepc    <= savePC;
        if (exception) begin
          mcause <= {24'b0, exceptionCode};
          mtval  <= exceptionValue;
        end else begin
          mcause <= {1'b1, 26'b0, cause};
          mtval  <= '0;
        end
      end else if (do_iret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end
    end
  end

  always_comb begin
    RD = '0;
    case (A)
      5'd0: RD[1:0] = {st_mpie, st_mie};
      5'd1: begin RD[NUM_IRQ-1:0] = mie_ext; RD[16] = mtie; end
      5'd2: begin RD[NUM_IRQ-1:0] = pending; RD[16] = systemTimerIRQ; end
      5'd3: RD = mepc;
      5'd4: RD = {mtvec_base, mtvec_mode};
      5'd5: RD = mcause;
      5'd6: RD = mtval;
      5'd7: RD = mscratch;
      5'd8: RD[NUM_IRQ-1:0] = mtrig;
      default: RD = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Directed scoreboard bench for irq_trap_ctrl (NUM_IRQ=4).
module tb_irq_trap_ctrl;

  logic        CLK = 1'b0;
  logic        reset;
  logic        trap;
  logic [31:0] savePC, nextPC;
  logic        iret;
  logic [3:0]  externalIRQ;
  logic        systemTimerIRQ, exception;
  logic [7:0]  exceptionCode;
  logic [31:0] exceptionValue;
  logic [4:0]  A;
  logic        WE;
  logic [31:0] WD, RD;

  irq_trap_ctrl #(.NUM_IRQ(4)) dut (
    .CLK(CLK), .reset(reset), .trap(trap), .savePC(savePC), .nextPC(nextPC),
    .iret(iret), .externalIRQ(externalIRQ), .systemTimerIRQ(systemTimerIRQ),
    .exception(exception), .exceptionCode(exceptionCode), .exceptionValue(exceptionValue),
    .A(A), .WE(WE), .WD(WD), .RD(RD)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: observed %h required an expectation", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    A = a; WD = d; WE = 1'b1;
    step();
    WE = 1'b0;
  endtask

  task automatic chk_rd(input logic [4:0] a);
    A = a;
    #1;
    chk(RD);
  endtask

  task automatic chk_trap();
    #1;
    chk({31'b0, trap});
    chk(nextPC);
  endtask

  initial begin
    reset = 1'b0; savePC = '0; iret = 1'b0; externalIRQ = '0; systemTimerIRQ = 1'b0;
    exception = 1'b0; exceptionCode = '0; exceptionValue = '0; A = '0; WE = 1'b0; WD = '0;
    step(); step();

    for (int i = 0; i <= 8; i++) begin
      expect_val($sformatf("reset_csr%0d", i), 32'h0);
      chk_rd(i[4:0]);
    end
    expect_val("reset_trap", 32'h0);
    expect_val("reset_nextpc", 32'h0);
    chk_trap();
    reset = 1'b1;
    step();

    // Level interrupt on line 2
    wr(5'd4, 32'h100);
    wr(5'd0, 32'h1);
    wr(5'd1, 32'h4);
    wr(5'd8, 32'h0);
    savePC = 32'h4000_0040;
    externalIRQ[2] = 1'b1;
    expect_val("lvl_trap_early", 32'h0);
    expect_val("lvl_trap", 32'h1);
    expect_val("lvl_nextpc", 32'h100);
    step();
    #1 chk({31'b0, trap});
    step();
    chk_trap();
    step();
    expect_val("lvl_mcause", 32'h8000_0012);
    expect_val("lvl_mepc", 32'h4000_0040);
    expect_val("lvl_mstatus", 32'h2);
    expect_val("lvl_mtval", 32'h0);
    chk_rd(5'd5); chk_rd(5'd3); chk_rd(5'd0); chk_rd(5'd6);
    externalIRQ[2] = 1'b0;
    step(); step(); step();

    // iret with same-cycle mstatus write: iret wins
    iret = 1'b1; A = 5'd0; WD = 32'h0; WE = 1'b1;
    expect_val("iret_trap", 32'h1);
    expect_val("iret_nextpc", 32'h4000_0040);
    chk_trap();
    step();
    iret = 1'b0; WE = 1'b0;
    expect_val("iret_mstatus", 32'h3);
    chk_rd(5'd0);

    // Edge source 0
    wr(5'd0, 32'h0);
    wr(5'd1, 32'h1);
    wr(5'd8, 32'h1);
    externalIRQ[0] = 1'b1; step(); externalIRQ[0] = 1'b0;
    step(); step(); step(); step();
    expect_val("edge_mip_held", 32'h1);
    chk_rd(5'd2);
    wr(5'd2, 32'h1);
    expect_val("edge_mip_w1c", 32'h0);
    chk_rd(5'd2);
    externalIRQ[0] = 1'b1; step(); externalIRQ[0] = 1'b0;
    step(); step(); step();
    expect_val("edge_mip_again", 32'h1);
    expect_val("edge_trap_masked", 32'h0);
    chk_rd(5'd2);
    chk({31'b0, trap});
    savePC = 32'h4000_0080;
    wr(5'd0, 32'h1);
    expect_val("edge_trap", 32'h1);
    expect_val("edge_nextpc", 32'h100);
    chk_trap();
    step();
    expect_val("edge_mip_autoclr", 32'h0);
    expect_val("edge_mcause", 32'h8000_0010);
    expect_val("edge_mepc", 32'h4000_0080);
    chk_rd(5'd2); chk_rd(5'd5); chk_rd(5'd3);

    // Exception beats a pending, enabled interrupt
    wr(5'd8, 32'h0);
    externalIRQ[0] = 1'b1;
    step(); step();
    wr(5'd0, 32'h1);
    savePC = 32'h5000;
    exception = 1'b1; exceptionCode = 8'd2; exceptionValue = 32'hDEAD;
    expect_val("exc_trap", 32'h1);
    expect_val("exc_nextpc", 32'h100);
    chk_trap();
    step();
    exception = 1'b0;
    expect_val("exc_mcause", 32'h2);
    expect_val("exc_mtval", 32'hDEAD);
    expect_val("exc_mepc", 32'h5000);
    expect_val("exc_mip", 32'h1);
    chk_rd(5'd5); chk_rd(5'd6); chk_rd(5'd3); chk_rd(5'd2);
    externalIRQ[0] = 1'b0;
    step(); step(); step();

    // Timer interrupt, vectored if built with the feature
    wr(5'd1, 32'h1_0000);
    wr(5'd4, 32'h201);
    wr(5'd0, 32'h1);
`ifdef IRQ_TRAP_VECTORED_EN
    expect_val("tmr_mtvec", 32'h201);
`else
    expect_val("tmr_mtvec", 32'h200);
`endif
    chk_rd(5'd4);
    systemTimerIRQ = 1'b1;
    expect_val("tmr_trap", 32'h1);
`ifdef IRQ_TRAP_VECTORED_EN
    expect_val("tmr_nextpc", 32'h21C);
`else
    expect_val("tmr_nextpc", 32'h200);
`endif
    chk_trap();
    step();
    systemTimerIRQ = 1'b0;
    expect_val("tmr_mcause", 32'h8000_0007);
    expect_val("tmr_mtval", 32'h0);
    expect_val("tmr_mstatus", 32'h2);
    chk_rd(5'd5); chk_rd(5'd6); chk_rd(5'd0);

    // Asynchronous reset mid-operation drops in-flight edge
    wr(5'd8, 32'h2);
    externalIRQ[1] = 1'b1;
    step();
    #2 reset = 1'b0;
    externalIRQ[1] = 1'b0;
    expect_val("arst_mstatus", 32'h0);
    expect_val("arst_trap", 32'h0);
    chk_rd(5'd0);
    chk({31'b0, trap});
    step();
    reset = 1'b1;
    step(); step(); step();
    expect_val("arst_mip", 32'h0);
    chk_rd(5'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
